// File: rtl/minmax_tracker.sv
// Tracks the signed running max/min over one frame of convolution results for the rescale stage.
// Define MINMAX_FRAME_CHECK_EN to flag frames whose pixel count differs from FRAME_PIXELS.
module minmax_tracker #(
    parameter int unsigned NB_PIXEL     = 19,
    parameter int unsigned NB_COUNT     = 20,
    parameter int unsigned FRAME_PIXELS = 65536
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_valid,
    input  logic signed [NB_PIXEL-1:0] i_pixel,
    input  logic                       i_last,
    output logic signed [NB_PIXEL-1:0] o_maxByte,
    output logic signed [NB_PIXEL-1:0] o_minByte,
    output logic                       o_endSignal,
    output logic                       o_resultValid,
    output logic [NB_COUNT-1:0]        o_pixelCount,
    output logic                       o_frameError
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    localparam logic signed [NB_PIXEL-1:0] PixMin   = {1'b1, {(NB_PIXEL-1){1'b0}}};
    localparam logic signed [NB_PIXEL-1:0] PixMax   = {1'b0, {(NB_PIXEL-1){1'b1}}};
    localparam logic [NB_COUNT-1:0]        CountMax = {NB_COUNT{1'b1}};
    localparam logic [NB_COUNT-1:0]        CountOne = {{(NB_COUNT-1){1'b0}}, 1'b1};

    state_e              state_q;
    logic [NB_COUNT-1:0] count_inc;
    logic                new_frame;

    always_comb begin
        count_inc = (o_pixelCount == CountMax) ? CountMax : o_pixelCount + CountOne;
    end

    // IDLE and DONE both treat a valid pixel as the first pixel of a new frame
    assign new_frame = i_valid && (state_q != StScan);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q       <= StIdle;
            o_maxByte     <= PixMin;
            o_minByte     <= PixMax;
            o_endSignal   <= 1'b0;
            o_resultValid <= 1'b0;
            o_pixelCount  <= '0;
        end else begin
            o_endSignal <= 1'b0;
            if (new_frame) begin
                o_maxByte     <= i_pixel;
                o_minByte     <= i_pixel;
                o_pixelCount  <= CountOne;
                o_endSignal   <= i_last;
                o_resultValid <= i_last;
                state_q       <= i_last ? StDone : StScan;
            end else if (i_valid) begin
                if (i_pixel > o_maxByte) o_maxByte <= i_pixel;
                if (i_pixel < o_minByte) o_minByte <= i_pixel;
                o_pixelCount <= count_inc;
                if (i_last) begin
                    o_endSignal   <= 1'b1;
                    o_resultValid <= 1'b1;
                    state_q       <= StDone;
                end
            end
        end
    end

`ifdef MINMAX_FRAME_CHECK_EN
    localparam logic [NB_COUNT:0] FrameTarget = (NB_COUNT+1)'(FRAME_PIXELS);

    // Sticky within a frame: an overrun mid-frame stays flagged through DONE
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_frameError <= 1'b0;
        end else if (new_frame) begin
            o_frameError <= i_last && ({1'b0, CountOne} != FrameTarget);
        end else if (i_valid) begin
            o_frameError <= o_frameError
                          || ({1'b0, count_inc} > FrameTarget)
                          || (i_last && ({1'b0, count_inc} != FrameTarget));
        end
    end
`else
    assign o_frameError = 1'b0;
`endif

endmodule

// File: tb/tb_minmax_tracker.sv
// Scoreboard bench for minmax_tracker: frame results are queued at drive time and
// compared when the DUT raises its end pulse.
module tb_minmax_tracker;

    localparam int NP = 19;
    localparam int NC = 20;
    localparam int FP = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 valid;
    logic signed [NP-1:0] pixel;
    logic                 last;
    logic signed [NP-1:0] max_o, min_o;
    logic                 end_o, rv_o, err_o;
    logic [NC-1:0]        cnt_o;

    minmax_tracker #(
        .NB_PIXEL    (NP),
        .NB_COUNT    (NC),
        .FRAME_PIXELS(FP)
    ) dut (
        .i_clock      (clk),
        .i_reset      (reset),
        .i_valid      (valid),
        .i_pixel      (pixel),
        .i_last       (last),
        .o_maxByte    (max_o),
        .o_minByte    (min_o),
        .o_endSignal  (end_o),
        .o_resultValid(rv_o),
        .o_pixelCount (cnt_o),
        .o_frameError (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [NP-1:0] mx;
        logic signed [NP-1:0] mn;
        logic [NC-1:0]        cnt;
        logic                 err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_ends   = 0;
    int   n_pushes = 0;

    // Reference model state
    logic                 in_frame = 1'b0;
    logic signed [NP-1:0] m_max, m_min;
    logic [NC-1:0]        m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    task automatic send(input logic v, input int p, input logic l);
        exp_t e;
        @(posedge clk);
        #1;
        valid = v;
        pixel = p[NP-1:0];
        last  = l;
        if (v) begin
            if (!in_frame) begin
                m_max = p[NP-1:0];
                m_min = p[NP-1:0];
                m_cnt = 1;
            end else begin
                if ($signed(p[NP-1:0]) > m_max) m_max = p[NP-1:0];
                if ($signed(p[NP-1:0]) < m_min) m_min = p[NP-1:0];
                m_cnt = m_cnt + 1;
            end
            in_frame = !l;
            if (l) begin
                e.mx  = m_max;
                e.mn  = m_min;
                e.cnt = m_cnt;
`ifdef MINMAX_FRAME_CHECK_EN
                e.err = (m_cnt != FP);
`else
                e.err = 1'b0;
`endif
                exp_q.push_back(e);
                n_pushes++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 0, 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        @(negedge clk);
        check({tag, "_max"}, max_o, -(64'sd1 <<< (NP - 1)));
        check({tag, "_min"}, min_o, (64'sd1 <<< (NP - 1)) - 1);
        check({tag, "_end"}, end_o, 0);
        check({tag, "_rv"},  rv_o,  0);
        check({tag, "_cnt"}, cnt_o, 0);
        check({tag, "_err"}, err_o, 0);
    endtask

    // Monitor: pop the scoreboard on every end pulse; the pulse must last exactly one cycle
    logic prev_end = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (prev_end) check("end_width", end_o, 0);
        if (end_o) begin
            n_ends++;
            if (exp_q.size() == 0) begin
                check("spurious_end", end_o, 0);
            end else begin
                e = exp_q.pop_front();
                check("frame_max", max_o, e.mx);
                check("frame_min", min_o, e.mn);
                check("frame_cnt", cnt_o, e.cnt);
                check("frame_err", err_o, e.err);
                check("frame_rv",  rv_o,  1);
            end
        end
        prev_end = end_o;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    int gap_pix[4] = '{5, -3, 12, 0};

    initial begin
        reset = 1'b1;
        valid = 1'b0;
        pixel = '0;
        last  = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_vals("reset");

        // Basic frame, then results must hold while idle in DONE
        send(1, 5, 0); send(1, -3, 0); send(1, 12, 0); send(1, 0, 1);
        idle(3);
        @(negedge clk);
        check("done_hold_rv",  rv_o,  1);
        check("done_hold_max", max_o, 12);

        // Same frame with two idle cycles after each pixel
        for (int i = 0; i < 4; i++) begin
            send(1, gap_pix[i], i == 3);
            idle(1);
            @(negedge clk);
            check("gap_cnt", cnt_o, m_cnt);
            check("gap_max", max_o, m_max);
            check("gap_min", min_o, m_min);
            idle(1);
        end

        // Full-range extremes
        send(1, -262144, 0); send(1, 262143, 1);
        idle(2);

        // Single-pixel frame
        send(1, -7, 1);
        idle(2);

        // Back-to-back frames; result valid drops after the second frame's first pixel
        send(1, 1, 0); send(1, 2, 1); send(1, -9, 0);
        send(1, 4, 1);
        @(negedge clk);
        check("rv_drop", rv_o, 0);
        idle(2);

        // Short frame: flagged only when the frame check is built in
        send(1, 7, 0); send(1, 8, 0); send(1, 9, 1);
        idle(2);

        // Reset mid-frame abandons it without an end pulse
        send(1, 50, 0); send(1, 60, 0);
        @(posedge clk);
        #1 reset = 1'b1; valid = 1'b0;
        in_frame = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        check_reset_vals("midreset");
        idle(4);

        // Reset wins over a coincident valid pixel
        @(posedge clk);
        #1 reset = 1'b1; valid = 1'b1; pixel = 100; last = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0; valid = 1'b0; last = 1'b0;
        check_reset_vals("rstvalid");

        idle(5);
        check("end_pulses", n_ends, n_pushes);
        check("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
